// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the byte-enable data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dmem_state_e;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering: byte enables and shifted store data toward the array,
// byte selection plus sign/zero extension from the array.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int DATA_W         = 32,
  localparam int BYTES_PER_WORD = bytes_per_word(DATA_W),
  localparam int OFF_W          = off_w(DATA_W)
) (
  input  logic [OFF_W-1:0]          off,
  input  mem_size_e                 size,
  input  logic                      uns,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rword,
  output logic [BYTES_PER_WORD-1:0] be,
  output logic [DATA_W-1:0]         wdata_sh,
  output logic [DATA_W-1:0]         rdata_ext
);

  logic [DATA_W-1:0] lane_mask;
  int                nbytes;

  // Left-justify the field so an arithmetic right shift replicates its top bit.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input int nbits, input logic u);
    logic signed [DATA_W-1:0] sv;
    int                       sa;
    sa = DATA_W - nbits;
    sv = signed'(v << sa);
    if (u) return (v << sa) >> sa;
    return sv >>> sa;
  endfunction

  always_comb begin
    nbytes = 1 << size;
    if (nbytes > BYTES_PER_WORD) nbytes = BYTES_PER_WORD;
    lane_mask = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++)
      if (b < nbytes) lane_mask[8*b +: 8] = 8'hFF;
    be        = BYTES_PER_WORD'((1 << nbytes) - 1) << off;
    wdata_sh  = (wdata & lane_mask) << {off, 3'b000};
    rdata_ext = extend(rword >> {off, 3'b000}, 8 * nbytes, uns);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory for the MEM stage: valid/ready requests, one-cycle response,
// zero-fill on reset. Define DMEM_ERR_EN to flag misaligned/out-of-range/illegal-size faults.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int BYTES_PER_WORD = bytes_per_word(DATA_W);
  localparam int OFF_W          = off_w(DATA_W);
  localparam int IDX_W          = $clog2(DEPTH_WORDS);

  dmem_state_e               state, state_nxt;
  logic [IDX_W-1:0]          cnt, cnt_nxt;
  logic                      clr_we, acc, fault;
  mem_size_e                 size_eff;
  logic [OFF_W-1:0]          off_raw, align_mask, off_al;
  logic [IDX_W-1:0]          idx;
  logic [BYTES_PER_WORD-1:0] st_be, unused_ld_be;
  logic [DATA_W-1:0]         st_wdata, unused_ld_wdata, unused_st_ext, ld_ext, rword;
  logic [DATA_W-1:0]         mem [DEPTH_WORDS];
  logic                      vld_p1;
  logic [DATA_W-1:0]         rdata_p1;

  // ---- Stage p0: request decode ----
  always_comb begin
    size_eff = mem_size_e'(req_size);
    if (DATA_W == 32 && size_eff == SZ_D) size_eff = SZ_W;
    off_raw    = req_addr[OFF_W-1:0];
    align_mask = OFF_W'((1 << size_eff) - 1);
    off_al     = off_raw & ~align_mask;
    idx        = req_addr[OFF_W +: IDX_W];
  end

  assign acc   = req_valid & req_ready;
  assign rword = mem[idx];

`ifdef DMEM_ERR_EN
  logic err_p1;
  assign fault = (|(off_raw & align_mask)) ||
                 ((req_addr >> (OFF_W + IDX_W)) != '0) ||
                 (DATA_W == 32 && req_size == 2'b11);
  assign rsp_err = err_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   err_p1 <= 1'b0;
    else if (acc) err_p1 <= fault;
  end
`else
  // Upper address bits are ignored: the index wraps modulo the depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(req_addr >> (OFF_W + IDX_W));
  assign fault          = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  dmem_lane_align #(.DATA_W(DATA_W)) u_st_align (
    .off(off_al), .size(size_eff), .uns(req_unsigned), .wdata(req_wdata), .rword('0),
    .be(st_be), .wdata_sh(st_wdata), .rdata_ext(unused_st_ext)
  );

  dmem_lane_align #(.DATA_W(DATA_W)) u_ld_align (
    .off(off_al), .size(size_eff), .uns(req_unsigned), .wdata('0), .rword(rword),
    .be(unused_ld_be), .wdata_sh(unused_ld_wdata), .rdata_ext(ld_ext)
  );

  // Clear writes and request stores share the single write port.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (acc && req_we && !fault) begin
      for (int b = 0; b < BYTES_PER_WORD; b++)
        if (st_be[b]) mem[idx][8*b +: 8] <= st_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + IDX_W'(1);
        if (cnt == IDX_W'(DEPTH_WORDS - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = cnt;
        end
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // ---- Stage p1: registered response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= acc;
      if (acc) rdata_p1 <= (req_we || fault) ? '0 : ld_ext;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_rdata = rdata_p1;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl (32-bit words, 16 words) against a byte-addressed memory model.
module tb_dmem_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mem_b [NBYTES];
  logic [31:0] last_rd;
  logic        last_err;

  dmem_ctrl #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
  endtask

  // Reference behaviour over a flat byte array.
  task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int n, a;
    logic [31:0] v;
    n  = 1 << size;
    rd = '0;
    er = 1'b0;
`ifdef DMEM_ERR_EN
    if (n > 4 || (int'(addr) % n) != 0 || int'(addr) >= NBYTES) begin
      er = 1'b1;
      return;
    end
    a = int'(addr);
`else
    if (n > 4) n = 4;
    a = ((int'(addr) % NBYTES) / n) * n;
`endif
    if (we) begin
      for (int i = 0; i < n; i++) mem_b[a + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input string tag);
    logic [31:0] er;
    logic        ee;
    model(we, addr, size, uns, wd, er, ee);
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_rdata"}, rsp_rdata, er);
    chk({tag, "_err"}, rsp_err, ee);
    last_rd  = rsp_rdata;
    last_err = rsp_err;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_vld", rsp_valid, 0);
  endtask

  task automatic rand_ops(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h4F)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, "rnd");
    end
  endtask

  initial begin
    int  n;
    bit  got;
    model_clear();

    // Power-up reset and clear sequence
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_init", init_done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_ready", req_ready, 0);
      chk("clr_init", init_done, 0);
      @(posedge clk); #1;
    end
    chk("clr_done_ready", req_ready, 1);
    chk("clr_done_init", init_done, 1);

    // Directed accesses
    issue(0, 32'h0, 2'b10, 0, 0, "ld0");            chk("ld0_c", last_rd, 32'h0);
    issue(1, 32'h4, 2'b10, 0, 32'hDEADBEEF, "st4");
    issue(0, 32'h4, 2'b10, 0, 0, "ld4");            chk("ld4_c", last_rd, 32'hDEADBEEF);
    idle();
    issue(1, 32'h6, 2'b00, 0, 32'h000000AA, "stb6");
    issue(0, 32'h4, 2'b10, 0, 0, "ld4b");           chk("ld4b_c", last_rd, 32'hDEAABEEF);
    issue(0, 32'h6, 2'b00, 0, 0, "ldb6s");          chk("ldb6s_c", last_rd, 32'hFFFFFFAA);
    issue(0, 32'h6, 2'b00, 1, 0, "ldb6u");          chk("ldb6u_c", last_rd, 32'h000000AA);
    issue(1, 32'h8, 2'b01, 0, 32'h00008001, "sth8");
    issue(0, 32'h8, 2'b01, 0, 0, "ldh8s");          chk("ldh8s_c", last_rd, 32'hFFFF8001);
    issue(0, 32'h8, 2'b01, 1, 0, "ldh8u");          chk("ldh8u_c", last_rd, 32'h00008001);
    issue(0, 32'h5, 2'b10, 0, 0, "ld5");
    issue(1, 32'h40, 2'b10, 0, 32'h12345678, "st40");
    issue(0, 32'h0, 2'b10, 0, 0, "ld0b");
    issue(0, 32'h4, 2'b11, 0, 0, "ldd4");
`ifdef DMEM_ERR_EN
    chk("ldd4_err_c", last_err, 1);
    chk("ld0b_c", last_rd, 32'h0);
`else
    chk("ldd4_c", last_rd, 32'hDEAABEEF);
    chk("ld0b_c", last_rd, 32'hDEAABEEF);
`endif

    rand_ops(150);

    // Reset while a response is pending
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_vld_pre", rsp_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_vld_drop", rsp_valid, 0);
    chk("mid_ready", req_ready, 0);
    chk("mid_init", init_done, 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b10; req_unsigned = 1'b0;
    n = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        got = 1'b1;
        n = i;
      end
    end
    req_valid = 1'b0;
    chk("reclr_latency", n, 17);
    chk("reclr_ld0", rsp_rdata, 0);
    issue(0, 32'h4, 2'b10, 0, 0, "reclr_ld4");      chk("reclr_ld4_c", last_rd, 32'h0);

    rand_ops(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
